inv_montgomery_gen: RTL and testbench

- Parametrised successor to the fixed-width Montgomery inverter used by the x25519 datapath.
- Computes the modular inverse of X modulo an odd modulus M in one of two run-time modes:
  - Montgomery-domain output: X^-1·2^N mod M
  - Plain output: X^-1 mod M
- Phase 1 is the Kaliski almost-inverse; phase 2 is the mod-M halving correction.
- Adds operand validation with an error flag, and optionally constant-time operation for side-channel-sensitive use.

---
 rtl/inv_pkg.sv | 9 +
 rtl/inv_halve_mod.sv | 12 +
 rtl/inv_montgomery_gen.sv | 117 +++++++++++
 tb/tb_inv_montgomery_gen.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/inv_pkg.sv
// inv_pkg: shared FSM states, mode constants and counter-width helper for the Montgomery inverter.
package inv_pkg;
  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_LOOP1, S_FIX, S_LOOP2, S_DONE} state_t;
  localparam logic MODE_MONT = 1'b0;
  localparam logic MODE_PLAIN = 1'b1;
  function automatic int kw_of(input int n);
    return $clog2(2 * n + 1);
  endfunction
endpackage

// File: rtl/inv_halve_mod.sv
// inv_halve_mod: r/2 mod M for odd M, as (r + (r[0] ? M : 0)) >> 1 on N+1 bits.
module inv_halve_mod #(
  parameter int N = 255
) (
  input  logic [N:0]   r,
  input  logic [N-1:0] m,
  output logic [N:0]   y
);
  logic [N:0] sum;
  assign sum = r + (r[0] ? {1'b0, m} : '0);
  assign y = sum >> 1;
endmodule

// File: rtl/inv_montgomery_gen.sv
// inv_montgomery_gen: Kaliski almost-inverse plus mod-M halving, Montgomery or plain output.
// Define INV_MONT_CONST_TIME_EN for fixed-latency loops with dummy iterations.
module inv_montgomery_gen
  import inv_pkg::*;
#(
  parameter int N = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] X,
  input  logic [N-1:0] M,
  input  logic         mode_plain,
  input  logic         req_valid,
  output logic         req_ready,
  output logic         req_busy,
  output logic [N-1:0] R,
  output logic         err,
  output logic         res_valid,
  input  logic         res_ready
);
`ifdef INV_MONT_CONST_TIME_EN
  localparam bit CT = 1'b1;
`else
  localparam bit CT = 1'b0;
`endif
  localparam int KW = kw_of(N);
  localparam logic [KW-1:0] L1_LAST = KW'(2 * N - 1);
  localparam logic [KW-1:0] L2_MONT_LAST = KW'(N - 1);

  state_t state_q, state_d;
  logic [N-1:0] x_q, x_d, m_q, m_d, u_q, u_d, v_q, v_d, res_q, res_d;
  logic [N:0] r_q, r_d, s_q, s_d, sh_q, sh_d, r_half, sh_half, r_red, r_sub;
  logic [KW-1:0] k_q, k_d, h_q, h_d, c_q, c_d;
  logic plain_q, plain_d, err_q, err_d, bad, l1_end, l2_end;

  inv_halve_mod #(.N(N)) u_half_r (.r(r_q), .m(m_q), .y(r_half));
  // Shadow halver keeps per-cycle switching activity uniform after h runs out.
  inv_halve_mod #(.N(N)) u_half_sh (.r(sh_q), .m(m_q), .y(sh_half));

  assign bad = !m_q[0] || !m_q[N-1] || x_q == '0 || x_q >= m_q;
  assign r_sub = (r_q >= {1'b0, m_q}) ? r_q - {1'b0, m_q} : r_q;
  assign r_red = {1'b0, m_q} - r_sub;
  assign l1_end = CT ? c_q == L1_LAST : v_q == '0;
  assign l2_end = CT ? c_q == (plain_q == MODE_PLAIN ? L1_LAST : L2_MONT_LAST) : h_q == '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = req_valid ? S_CHECK : S_IDLE;
      S_CHECK: state_d = (bad && !CT) ? S_DONE : S_LOOP1;
      S_LOOP1: state_d = l1_end ? S_FIX : S_LOOP1;
      S_FIX:   state_d = (u_q != N'(1) && !CT) ? S_DONE : S_LOOP2;
      S_LOOP2: state_d = l2_end ? S_DONE : S_LOOP2;
      S_DONE:  state_d = res_ready ? S_IDLE : S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = state_q == S_IDLE && req_valid;
    req_busy = state_q inside {S_CHECK, S_LOOP1, S_FIX, S_LOOP2};
    res_valid = state_q == S_DONE;
    R = res_q;
    err = err_q;
  end

  always_comb begin
    x_d = x_q; m_d = m_q; plain_d = plain_q; u_d = u_q; v_d = v_q; r_d = r_q; s_d = s_q;
    sh_d = sh_q; k_d = k_q; h_d = h_q; c_d = c_q; err_d = err_q; res_d = res_q;
    case (state_q)
      S_IDLE: if (req_valid) begin
        x_d = X; m_d = M; plain_d = mode_plain;
      end
      S_CHECK: begin
        err_d = bad; u_d = m_q; v_d = bad ? '0 : x_q;
        r_d = '0; s_d = (N+1)'(1); k_d = '0; c_d = '0; res_d = '0;
      end
      S_LOOP1: begin
        c_d = c_q + 1'b1;
        if (v_q != '0) begin
          k_d = k_q + 1'b1;
          if (!u_q[0]) begin u_d = u_q >> 1; s_d = s_q << 1; end
          else if (!v_q[0]) begin v_d = v_q >> 1; r_d = r_q << 1; end
          else if (u_q > v_q) begin u_d = (u_q - v_q) >> 1; r_d = r_q + s_q; s_d = s_q << 1; end
          else begin v_d = (v_q - u_q) >> 1; s_d = s_q + r_q; r_d = r_q << 1; end
        end
      end
      S_FIX: begin
        err_d = err_q || u_q != N'(1);
        r_d = r_red; sh_d = r_red; c_d = '0;
        h_d = err_d ? '0 : (plain_q == MODE_MONT ? k_q - KW'(N) : k_q);
      end
      S_LOOP2: begin
        c_d = c_q + 1'b1;
        if (h_q != '0) begin r_d = r_half; h_d = h_q - 1'b1; end
        else sh_d = sh_half;
        res_d = err_q ? '0 : r_d[N-1:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q <= '0; m_q <= '0; plain_q <= 1'b0; u_q <= '0; v_q <= '0; r_q <= '0; s_q <= '0;
      sh_q <= '0; k_q <= '0; h_q <= '0; c_q <= '0; err_q <= 1'b0; res_q <= '0;
    end else begin
      x_q <= x_d; m_q <= m_d; plain_q <= plain_d; u_q <= u_d; v_q <= v_d; r_q <= r_d; s_q <= s_d;
      sh_q <= sh_d; k_q <= k_d; h_q <= h_d; c_q <= c_d; err_q <= err_d; res_q <= res_d;
    end
  end
endmodule

// File: tb/tb_inv_montgomery_gen.sv
// tb_inv_montgomery_gen: randomized self-checking bench for N=8 and N=255 instances of inv_montgomery_gen.
module tb_inv_montgomery_gen;
`ifdef INV_MONT_CONST_TIME_EN
  localparam bit CT = 1'b1;
`else
  localparam bit CT = 1'b0;
`endif
  localparam logic [254:0] P = {255{1'b1}} - 255'd18;

  logic clk, rst, plain, res_ready, rv8, rv255, big;
  logic [254:0] xin, min, r255;
  logic [7:0] r8;
  logic rdy8, rdy255, busy8, busy255, err8, err255, val8, val255;
  logic cur_val, cur_rdy, cur_busy, cur_err;
  logic [254:0] cur_r;
  int tests = 0, fails = 0;

  inv_montgomery_gen #(.N(8)) d8 (
    .clk(clk), .rst(rst), .X(xin[7:0]), .M(min[7:0]), .mode_plain(plain), .req_valid(rv8),
    .req_ready(rdy8), .req_busy(busy8), .R(r8), .err(err8), .res_valid(val8), .res_ready(res_ready));
  inv_montgomery_gen #(.N(255)) d255 (
    .clk(clk), .rst(rst), .X(xin), .M(min), .mode_plain(plain), .req_valid(rv255),
    .req_ready(rdy255), .req_busy(busy255), .R(r255), .err(err255), .res_valid(val255), .res_ready(res_ready));

  assign cur_val = big ? val255 : val8;
  assign cur_rdy = big ? rdy255 : rdy8;
  assign cur_busy = big ? busy255 : busy8;
  assign cur_err = big ? err255 : err8;
  assign cur_r = big ? r255 : {247'b0, r8};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [254:0] mulmod(input logic [254:0] a, input logic [254:0] b, input logic [254:0] m);
    logic [509:0] p;
    p = {255'b0, a} * {255'b0, b};
    p = p % {255'b0, m};
    return p[254:0];
  endfunction

  function automatic logic [254:0] two_n_mod(input int n, input logic [254:0] m);
    logic [255:0] t;
    t = 256'd1 << n;
    t = t % {1'b0, m};
    return t[254:0];
  endfunction

  function automatic int gcd(input int a, input int b);
    int t;
    while (b != 0) begin t = a % b; a = b; b = t; end
    return a;
  endfunction

  function automatic int ct_lat(input int n, input bit p);
    return 3 + (p ? 4 : 3) * n;
  endfunction

  // Caller is at a negedge with the selected DUT idle; returns at a negedge.
  task automatic run(input bit b, input logic [254:0] x, input logic [254:0] m, input bit p,
                     input bit hold, output logic [254:0] r, output logic e, output int lat);
    big = b; xin = x; min = m; plain = p;
    if (b) rv255 = 1'b1; else rv8 = 1'b1;
    #1;
    tests++;
    if (cur_rdy !== 1'b1) begin fails++; $display("FAIL req_ready: got %b need 1", cur_rdy); end
    lat = 0;
    do begin
      @(negedge clk); rv8 = 1'b0; rv255 = 1'b0; lat++;
    end while (cur_val !== 1'b1 && lat < 4 * (b ? 255 : 8) + 10);
    tests++;
    if (cur_val !== 1'b1) begin fails++; $display("FAIL res_valid_timeout: got %b need 1 after %0d cycles", cur_val, lat); end
    r = cur_r; e = cur_err;
    if (!hold) begin
      res_ready = 1'b1; @(negedge clk); res_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rv8 = 0; rv255 = 0; res_ready = 0; big = 0; xin = '0; min = '0; plain = 0;
    repeat (2) @(negedge clk);
    tests++;
    if ({rdy8, busy8, val8, err8, r8, rdy255, busy255, val255, err255} !== '0 || r255 !== '0) begin
      fails++; $display("FAIL reset_outputs: got busy=%b/%b valid=%b/%b err=%b/%b need all 0", busy8, busy255, val8, val255, err8, err255);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_lat(input string nm, input int lat, input int n, input bit p, input bit chk_err, input bit e);
    bit bad;
    bad = CT ? lat != ct_lat(n, p) : chk_err ? lat != 2 : (lat < (e ? 3 : n + 3) || lat > 4 * n + 3);
    tests++;
    if (bad) begin fails++; $display("FAIL %s latency: got %0d (n=%0d plain=%0d)", nm, lat, n, p); end
  endtask

  task automatic test_n8_vectors();
    int vx[7] = '{2, 2, 1, 1, 0, 3, 15};
    int vm[7] = '{251, 251, 251, 251, 251, 250, 255};
    int vp[7] = '{1, 0, 0, 1, 0, 0, 0};
    int vr[7] = '{126, 128, 5, 1, 0, 0, 0};
    int ve[7] = '{0, 0, 0, 0, 1, 1, 1};
    int vc[7] = '{0, 0, 0, 0, 1, 1, 0};
    logic [254:0] r;
    logic e;
    int lat;
    for (int i = 0; i < 7; i++) begin
      run(1'b0, 255'(vx[i]), 255'(vm[i]), vp[i][0], 1'b0, r, e, lat);
      tests++;
      if (r !== 255'(vr[i]) || e !== ve[i][0]) begin
        fails++; $display("FAIL n8_vec[%0d]: got R=%0d err=%b need R=%0d err=%0d", i, r, e, vr[i], ve[i]);
      end
      check_lat($sformatf("n8_vec[%0d]", i), lat, 8, vp[i][0], vc[i][0], ve[i][0]);
    end
  endtask

  task automatic test_n8_random();
    logic [254:0] r;
    logic e;
    int lat, m, x, y, exp_r;
    bit p, exp_e, ce;
    for (int i = 0; i < 150; i++) begin
      m = $urandom_range(128, 255); x = $urandom_range(0, m); p = 1'($urandom_range(0, 1));
      ce = (m % 2 == 0) || x == 0 || x >= m;
      exp_e = ce || gcd(x, m) != 1;
      exp_r = 0;
      if (!exp_e) begin
        y = 1;
        while ((x * y) % m != 1) y++;
        exp_r = p ? y : (y * 256) % m;
      end
      run(1'b0, 255'(x), 255'(m), p, 1'b0, r, e, lat);
      tests++;
      if (r !== 255'(exp_r) || e !== exp_e) begin
        fails++; $display("FAIL n8_rand X=%0d M=%0d plain=%0d: got R=%0d err=%b need R=%0d err=%0d", x, m, p, r, e, exp_r, exp_e);
      end
      check_lat("n8_rand", lat, 8, p, ce, exp_e);
    end
  endtask

  task automatic test_hold();
    logic [254:0] r;
    logic e;
    int lat;
    bit moved;
    run(1'b0, 255'd2, 255'd251, 1'b1, 1'b1, r, e, lat);
    moved = 0;
    repeat (10) begin
      @(negedge clk);
      if (cur_val !== 1'b1 || cur_r !== 255'd126 || cur_err !== 1'b0) moved = 1;
    end
    tests++;
    if (moved) begin fails++; $display("FAIL hold_stable: got valid=%b R=%0d err=%b need 1/126/0", cur_val, cur_r, cur_err); end
    res_ready = 1'b1; @(negedge clk); res_ready = 1'b0;
    tests++;
    if (cur_val !== 1'b0 || cur_busy !== 1'b0) begin fails++; $display("FAIL hold_release: got valid=%b busy=%b need 0/0", cur_val, cur_busy); end
    run(1'b0, 255'd1, 255'd251, 1'b0, 1'b0, r, e, lat);
    tests++;
    if (r !== 255'd5 || e !== 1'b0) begin fails++; $display("FAIL back_to_back: got R=%0d err=%b need 5/0", r, e); end
  endtask

  task automatic test_n255();
    logic [254:0] r, x, tgt, pm;
    logic [255:0] w;
    logic e;
    int lat;
    bit p;
    for (int i = 0; i < 22; i++) begin
      p = 1'(i % 2);
      if (i < 2) x = 255'd9;
      else begin
        w = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        x = w[254:0] % P;
        if (x == '0) x = 255'd1;
      end
      tgt = p ? 255'd1 : two_n_mod(255, P);
      run(1'b1, x, P, p, 1'b0, r, e, lat);
      pm = mulmod(r, x, P);
      tests++;
      if (pm !== tgt || e !== 1'b0 || !(r < P)) begin
        fails++; $display("FAIL n255[%0d] plain=%0d: got R*X mod M=%h err=%b need %h err=0", i, p, pm, e, tgt);
      end
      check_lat("n255", lat, 255, p, 1'b0, 1'b0);
    end
  endtask

  task automatic test_extremes();
    logic [254:0] r;
    logic e;
    int lat;
    logic [254:0] xs[2];
    xs[0] = 255'd1; xs[1] = P - 255'd1;
    for (int i = 0; i < 2; i++) begin
      run(1'b1, xs[i], P, 1'b1, 1'b0, r, e, lat);
      tests++;
      if (r !== xs[i] || e !== 1'b0) begin fails++; $display("FAIL extreme[%0d]: got R=%h err=%b need %h err=0", i, r, e, xs[i]); end
      tests++;
      if (CT ? lat != 1023 : lat > 1023) begin fails++; $display("FAIL extreme_lat[%0d]: got %0d need %s1023", i, lat, CT ? "" : "<="); end
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    big = 1'b1; xin = 255'd9; min = P; plain = 1'b1; rv255 = 1'b1;
    @(negedge clk); rv255 = 1'b0;
    repeat (5) @(negedge clk);
    tests++;
    if (busy255 !== 1'b1) begin fails++; $display("FAIL mid_busy: got %b need 1", busy255); end
    #2 rst = 1'b1;
    #1;
    tests++;
    if ({busy255, val255, err255, rdy255} !== 4'b0 || r255 !== '0) begin
      fails++; $display("FAIL mid_reset: got busy=%b valid=%b err=%b R=%h need all 0", busy255, val255, err255, r255);
    end
    @(negedge clk); rst = 1'b0;
    seen = 0;
    repeat (20) begin @(negedge clk); if (val255 !== 1'b0 || busy255 !== 1'b0) seen = 1; end
    tests++;
    if (seen) begin fails++; $display("FAIL mid_abort: got valid/busy after reset need 0"); end
  endtask

  initial begin
    test_reset();
    test_n8_vectors();
    test_n8_random();
    test_hold();
    test_n255();
    test_extremes();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
